// File: rtl/puf_key_verifier.sv
// PUF key verifier: assembles a 64-bit key from 8 bytes, enrolls it as reference or
// reports its Hamming distance and match flag. Optional `PUF_FAILCNT_EN adds fail_count.
module puf_key_verifier #(
  parameter int NBYTES    = 8,
  parameter int HD_THRESH = 6,
  parameter int HD_W      = 7
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                start,
  input  logic                enroll,
  input  logic                byte_valid,
  input  logic [7:0]          byte_data,
  output logic                busy,
  output logic                done,
  output logic                match,
  output logic [HD_W-1:0]     hd,
  output logic                enrolled,
  output logic [8*NBYTES-1:0] key
`ifdef PUF_FAILCNT_EN
  ,
  output logic [15:0]         fail_count
`endif
);

  localparam int KEY_W = 8 * NBYTES;
  localparam int IDX_W = $clog2(NBYTES);
  localparam logic [IDX_W-1:0] LAST   = IDX_W'(NBYTES - 1);
  localparam logic [HD_W-1:0]  HD_MAX = HD_W'(KEY_W);
  localparam logic [HD_W-1:0]  THRESH = HD_W'(HD_THRESH);

  typedef enum logic [1:0] {IDLE, CAPTURE, COMPARE, DONE} state_t;

  state_t                 state;
  logic [IDX_W-1:0]       idx;
  logic [IDX_W-1:0]       cmp_idx;
  logic                   mode_enroll;
  logic [KEY_W-1:0]       ref_key;
  logic [KEY_W-1:0]       key_next;
  logic [HD_W-1:0]        hd_acc;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

  function automatic logic [HD_W-1:0] hd_add_sat(input logic [HD_W-1:0] a, input logic [3:0] b);
    logic [HD_W:0] s;
    s = {1'b0, a} + (HD_W+1)'(b);
    if (s > (HD_W+1)'(KEY_W)) return HD_MAX;
    return s[HD_W-1:0];
  endfunction

  // Key with the incoming byte merged, so the 8th byte is visible in the same edge
  always_comb begin
    key_next = key;
    key_next[8*idx +: 8] = byte_data;
  end

  assign hd_acc = hd_add_sat(hd, popcount8(key[8*cmp_idx +: 8] ^ ref_key[8*cmp_idx +: 8]));

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= IDLE;
      idx         <= '0;
      cmp_idx     <= '0;
      mode_enroll <= 1'b0;
      ref_key     <= '0;
      key         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      match       <= 1'b0;
      hd          <= '0;
      enrolled    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        state       <= CAPTURE;
        busy        <= 1'b1;
        idx         <= '0;
        cmp_idx     <= '0;
        hd          <= '0;
        match       <= 1'b0;
        mode_enroll <= enroll;
      end else begin
        case (state)
          CAPTURE: begin
            if (byte_valid) begin
              key <= key_next;
              if (idx == LAST) begin
                idx <= '0;
                if (mode_enroll) begin
                  ref_key  <= key_next;
                  enrolled <= 1'b1;
                  hd       <= '0;
                  match    <= 1'b0;
                  state    <= DONE;
                  done     <= 1'b1;
                end else if (enrolled) begin
                  cmp_idx <= '0;
                  state   <= COMPARE;
                end else begin
                  hd    <= HD_MAX;
                  match <= 1'b0;
                  state <= DONE;
                  done  <= 1'b1;
                end
              end else begin
                idx <= idx + 1'b1;
              end
            end
          end
          COMPARE: begin
            hd <= hd_acc;
            if (cmp_idx == LAST) begin
              match <= (hd_acc <= THRESH);
              state <= DONE;
              done  <= 1'b1;
            end else begin
              cmp_idx <= cmp_idx + 1'b1;
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef PUF_FAILCNT_EN
  logic fail_evt;

  // Counted on entry to DONE, i.e. whenever a verify result with match=0 is issued
  assign fail_evt = !start &&
                    ((state == CAPTURE && byte_valid && idx == LAST && !mode_enroll && !enrolled) ||
                     (state == COMPARE && cmp_idx == LAST && !(hd_acc <= THRESH)));

  always_ff @(posedge Clk) begin
    if (Rst) fail_count <= '0;
    else if (fail_evt && fail_count != 16'hFFFF) fail_count <= fail_count + 16'd1;
  end
`endif

  hd_bounded: assert property (@(posedge Clk) disable iff (Rst) hd <= HD_MAX);

endmodule

// File: tb/tb_puf_key_verifier.sv
// Scoreboard bench for puf_key_verifier: expectations are pushed when a transaction is
// driven and popped when done fires. fail_count checks follow `PUF_FAILCNT_EN.
module tb_puf_key_verifier;

  logic        Clk = 1'b0;
  logic        Rst, start, enroll, byte_valid;
  logic [7:0]  byte_data;
  logic        busy, done, match, enrolled;
  logic [6:0]  hd;
  logic [63:0] key;
`ifdef PUF_FAILCNT_EN
  logic [15:0] fail_count;
`endif

  puf_key_verifier dut (
    .Clk(Clk), .Rst(Rst), .start(start), .enroll(enroll),
    .byte_valid(byte_valid), .byte_data(byte_data),
    .busy(busy), .done(done), .match(match), .hd(hd),
    .enrolled(enrolled), .key(key)
`ifdef PUF_FAILCNT_EN
    , .fail_count(fail_count)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [6:0]  hd;
    logic        match;
    logic [63:0] key;
    logic        enr;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          done_seen = 0;
  logic [63:0] m_ref;
  bit          m_enr;
  int          m_fail;

  localparam logic [63:0] K0 = 64'h0000FFFFDEADBEEF;
  localparam logic [63:0] K1 = 64'h0123456789ABCDEF;

  always @(negedge Clk) if (done === 1'b1) done_seen++;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_start(input bit e);
    start = 1'b1; enroll = e;
    tick();
    start = 1'b0; enroll = 1'b0;
  endtask

  task automatic send_bytes(input logic [63:0] k, input int n);
    for (int i = 0; i < n; i++) begin
      byte_valid = 1'b1;
      byte_data  = k[8*i +: 8];
      tick();
    end
    byte_valid = 1'b0;
  endtask

  // Drives a full transaction, pushes its expectation, returns at the done cycle
  task automatic drive_txn(input bit e, input logic [63:0] k, input bit noise, output int lat);
    exp_t x;
    x.key = k;
    if (e) begin
      x.hd = 7'd0; x.match = 1'b0; x.lat = 1;
      m_ref = k; m_enr = 1'b1;
    end else if (!m_enr) begin
      x.hd = 7'd64; x.match = 1'b0; x.lat = 1;
    end else begin
      x.hd = 7'($countones(k ^ m_ref)); x.match = (x.hd <= 7'd6); x.lat = 9;
    end
    x.enr = m_enr;
    if (!e && !x.match) m_fail++;
    sb.push_back(x);
    do_start(e);
    send_bytes(k, 8);
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin
      byte_valid = noise;
      byte_data  = 8'h5A;
      tick();
      lat++;
    end
    byte_valid = 1'b0;
    if (done !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    Rst = 1'b1; start = 1'b0; enroll = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    m_ref = '0; m_enr = 1'b0; m_fail = 0;
    tick(); tick();
    Rst = 1'b0;
    n_cmp++;
    if ({busy, done, match, hd, enrolled, key} !== 75'd0) begin
      n_err++;
      $display("FAIL reset: got busy=%b done=%b match=%b hd=%0d enr=%b key=%h, want all zero",
               busy, done, match, hd, enrolled, key);
    end
  endtask

  task automatic test_no_ref();
    exp_t x; int lat;
    drive_txn(1'b0, K0, 1'b0, lat);
    x = sb.pop_front();
    n_cmp++;
    if ({hd, match, key, enrolled} !== {x.hd, x.match, x.key, x.enr} || lat != x.lat) begin
      n_err++;
      $display("FAIL no_ref: got hd=%0d match=%b key=%h enr=%b lat=%0d, want hd=%0d match=%b key=%h enr=%b lat=%0d",
               hd, match, key, enrolled, lat, x.hd, x.match, x.key, x.enr, x.lat);
    end
`ifdef PUF_FAILCNT_EN
    n_cmp++;
    if (fail_count !== 16'(m_fail)) begin
      n_err++;
      $display("FAIL no_ref_failcnt: got %0d, want %0d", fail_count, m_fail);
    end
`endif
  endtask

  task automatic test_enroll();
    exp_t x; int lat;
    drive_txn(1'b1, K0, 1'b0, lat);
    x = sb.pop_front();
    n_cmp++;
    if ({hd, match, key, enrolled, busy} !== {x.hd, x.match, x.key, x.enr, 1'b1} || lat != x.lat) begin
      n_err++;
      $display("FAIL enroll: got hd=%0d match=%b key=%h enr=%b busy=%b lat=%0d, want hd=%0d match=%b key=%h enr=%b busy=1 lat=%0d",
               hd, match, key, enrolled, busy, lat, x.hd, x.match, x.key, x.enr, x.lat);
    end
    tick();
    n_cmp++;
    if ({done, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL done_pulse: got done=%b busy=%b, want done=0 busy=0", done, busy);
    end
  endtask

  task automatic test_verify();
    logic [63:0] masks[7];
    exp_t x; int lat;
    masks = '{64'h0, 64'hFF, 64'h01, 64'h3F, 64'h7F, 64'h0100_0000_0080_0001, '1};
    for (int i = 0; i < 7; i++) begin
      drive_txn(1'b0, K0 ^ masks[i], 1'b0, lat);
      x = sb.pop_front();
      n_cmp++;
      if ({hd, match, key} !== {x.hd, x.match, x.key} || lat != x.lat) begin
        n_err++;
        $display("FAIL verify[%0d]: got hd=%0d match=%b key=%h lat=%0d, want hd=%0d match=%b key=%h lat=%0d",
                 i, hd, match, key, lat, x.hd, x.match, x.key, x.lat);
      end
    end
  endtask

  task automatic test_abort();
    exp_t x; int lat; int seen;
    // start after 5 bytes of a different key
    do_start(1'b0);
    send_bytes(64'hA5A5A5A5A5A5A5A5, 5);
    drive_txn(1'b0, K0 ^ 64'h0000_0100_0000_0000, 1'b0, lat);
    x = sb.pop_front();
    n_cmp++;
    if ({hd, match, key} !== {x.hd, x.match, x.key} || lat != x.lat) begin
      n_err++;
      $display("FAIL abort_capture: got hd=%0d match=%b key=%h lat=%0d, want hd=%0d match=%b key=%h lat=%0d",
               hd, match, key, lat, x.hd, x.match, x.key, x.lat);
    end
    // aborted enroll capture and aborted compare leave ref and done untouched
    tick();
    seen = done_seen;
    do_start(1'b1);
    send_bytes(K1, 5);
    do_start(1'b0);
    send_bytes(K1, 8);
    tick(); tick(); tick();
    drive_txn(1'b0, K0, 1'b0, lat);
    x = sb.pop_front();
    n_cmp++;
    if ({hd, match, key} !== {x.hd, x.match, x.key} || lat != x.lat) begin
      n_err++;
      $display("FAIL abort_compare: got hd=%0d match=%b key=%h lat=%0d, want hd=%0d match=%b key=%h lat=%0d",
               hd, match, key, lat, x.hd, x.match, x.key, x.lat);
    end
    tick();
    n_cmp++;
    if (done_seen - seen != 1) begin
      n_err++;
      $display("FAIL abort_no_done: got %0d done pulses, want 1", done_seen - seen);
    end
  endtask

  task automatic test_ignored_bytes();
    exp_t x; int lat; int seen; logic [63:0] k_before;
    k_before = key;
    seen = done_seen;
    send_bytes(64'hAAAAAAAAAAAAAAAA, 4);
    tick();
    n_cmp++;
    if ({key, busy} !== {k_before, 1'b0} || done_seen != seen) begin
      n_err++;
      $display("FAIL idle_bytes: got key=%h busy=%b pulses=%0d, want key=%h busy=0 pulses=%0d",
               key, busy, done_seen, k_before, seen);
    end
    drive_txn(1'b0, K0 ^ 64'h3, 1'b1, lat);
    x = sb.pop_front();
    n_cmp++;
    if ({hd, match, key} !== {x.hd, x.match, x.key} || lat != x.lat) begin
      n_err++;
      $display("FAIL compare_bytes: got hd=%0d match=%b key=%h lat=%0d, want hd=%0d match=%b key=%h lat=%0d",
               hd, match, key, lat, x.hd, x.match, x.key, x.lat);
    end
    // a fresh capture right after must start from byte index 0
    tick();
    drive_txn(1'b0, K0, 1'b0, lat);
    x = sb.pop_front();
    n_cmp++;
    if ({hd, match, key} !== {x.hd, x.match, x.key} || lat != x.lat) begin
      n_err++;
      $display("FAIL idx_after_idle: got hd=%0d match=%b key=%h lat=%0d, want hd=%0d match=%b key=%h lat=%0d",
               hd, match, key, lat, x.hd, x.match, x.key, x.lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] keys[4];
    bit          modes[4];
    exp_t x; int lat;
    keys  = '{K1, K1, K0, K1 ^ 64'h8000_0000_0000_0000};
    modes = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive_txn(modes[i], keys[i], 1'b0, lat);
      x = sb.pop_front();
      n_cmp++;
      if ({hd, match, key, enrolled} !== {x.hd, x.match, x.key, x.enr} || lat != x.lat) begin
        n_err++;
        $display("FAIL b2b[%0d]: got hd=%0d match=%b key=%h enr=%b lat=%0d, want hd=%0d match=%b key=%h enr=%b lat=%0d",
                 i, hd, match, key, enrolled, lat, x.hd, x.match, x.key, x.enr, x.lat);
      end
    end
    tick(); tick();
`ifdef PUF_FAILCNT_EN
    n_cmp++;
    if (fail_count !== 16'(m_fail)) begin
      n_err++;
      $display("FAIL failcnt_total: got %0d, want %0d", fail_count, m_fail);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_no_ref();
    test_enroll();
    test_verify();
    test_abort();
    test_ignored_bytes();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
